// File: rtl/feeder_bank.sv
// feeder_bank: multi-channel portion feeder plant model.
// Per channel: wheel counter, portion store, timed or manual refill.
module feeder_bank #(
   parameter int CHANNELS    = 4,
   parameter int PERIOD      = 65536,
   parameter int PORTIONS    = 10,
   parameter int REFILL      = 100,
   parameter int AUTO_REFILL = 1,
   parameter int CNT_W       = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [CHANNELS-1:0] ch_en,
   input  logic [CHANNELS-1:0] x,
   input  logic [CHANNELS-1:0] refill_req,
   input  logic                cnt_clr,
   output logic [CHANNELS-1:0] revolution,
   output logic [CHANNELS-1:0] remain,
   output logic [CHANNELS-1:0] feed,
   output logic [CHANNELS-1:0] refilled,
   output logic [CNT_W-1:0]    fed_count
);

   localparam int CW = $clog2(PERIOD);
   localparam int NW = $clog2(PORTIONS + 1);
   localparam int RW = (REFILL > 1) ? $clog2(REFILL) : 1;
   localparam int SW = CNT_W + $clog2(CHANNELS + 1);

   localparam logic [CW-1:0] HALF  = CW'(PERIOD / 2);
   localparam logic [CW-1:0] DROP  = CW'(PERIOD * 3 / 4);
   localparam logic [CW-1:0] TOP   = CW'(PERIOD - 1);
   localparam logic [NW-1:0] FULL  = NW'(PORTIONS);
   localparam logic [RW-1:0] RLOAD = RW'(REFILL - 1);
   localparam logic [CNT_W-1:0] CMAX = '1;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [CW-1:0] ctr;
      logic [NW-1:0] n_rem;
      logic [RW-1:0] rdly;
      logic          rfd;
      logic          act;
      logic          refill;

      assign act    = en & ch_en[i];
      assign refill = refill_req[i]
                    | ((AUTO_REFILL != 0) && (n_rem == '0) && (rdly == '0));

      assign feed[i]       = act & (ctr == DROP) & (n_rem != '0);
      assign revolution[i] = (ctr < HALF);
      assign remain[i]     = (n_rem != '0);
      assign refilled[i]   = rfd;

      always_ff @(posedge clk) begin
         if (rst) begin
            ctr   <= '0;
            n_rem <= FULL;
            rdly  <= RLOAD;
            rfd   <= 1'b0;
         end else begin
            rfd <= act & refill;
            if (act) begin
               // holding on the drop point still steps off it once
               if (x[i])
                  ctr <= (ctr == '0) ? TOP : ctr - CW'(1);
               else
                  ctr <= ctr - CW'(feed[i]);

               if (refill)
                  n_rem <= FULL;
               else
                  n_rem <= n_rem - NW'(feed[i]);

               if (n_rem != '0)
                  rdly <= RLOAD;
               else if (rdly != '0)
                  rdly <= rdly - RW'(1);
            end
         end
      end
   end

   logic [SW-1:0] sum;

   always_comb begin
      sum = SW'(fed_count);
      for (int i = 0; i < CHANNELS; i++)
         sum = sum + SW'(feed[i]);
   end

   always_ff @(posedge clk) begin
      if (rst)
         fed_count <= '0;
      else if (en) begin
         if (cnt_clr)
            fed_count <= '0;
         else
            fed_count <= (sum > SW'(CMAX)) ? CMAX : sum[CNT_W-1:0];
      end
   end

endmodule

// File: tb/tb_feeder_bank.sv
// tb_feeder_bank: directed checks of feeder_bank (2 channels, period 16).
// Second instance runs without auto refill for the manual-refill cases.
module tb_feeder_bank;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, en, cnt_clr;
   logic [1:0] ch_en, x, refill_req, refill_m;
   logic [1:0] rev, rem, feed, rfd;
   logic [1:0] rev_m, rem_m, feed_m, rfd_m;
   logic [3:0] cnt, cnt_m;

   int checks   = 0;
   int failures = 0;
   int n        = 0;

   feeder_bank #(
      .CHANNELS(2), .PERIOD(16), .PORTIONS(3), .REFILL(5),
      .AUTO_REFILL(1), .CNT_W(4)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .ch_en(ch_en), .x(x),
      .refill_req(refill_req), .cnt_clr(cnt_clr),
      .revolution(rev), .remain(rem), .feed(feed),
      .refilled(rfd), .fed_count(cnt)
   );

   feeder_bank #(
      .CHANNELS(2), .PERIOD(16), .PORTIONS(3), .REFILL(5),
      .AUTO_REFILL(0), .CNT_W(4)
   ) dut_m (
      .clk(clk), .rst(rst), .en(en), .ch_en(ch_en), .x(x),
      .refill_req(refill_m), .cnt_clr(cnt_clr),
      .revolution(rev_m), .remain(rem_m), .feed(feed_m),
      .refilled(rfd_m), .fed_count(cnt_m)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s n=%0d obs=%0h exp=%0h", tag, n, obs, exp);
      end
   endtask

   task automatic tick(input int k);
      repeat (k) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic tick_to(input int t);
      while (n < t) tick(1);
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; cnt_clr = 1'b0;
      ch_en = 2'b11; x = 2'b11; refill_req = 2'b00; refill_m = 2'b00;
      tick(2);
      rst = 1'b0; n = 0;

      // reset state and spinning wheel
      chk("rst_rev", 32'(rev), 32'h3);
      chk("rst_rem", 32'(rem), 32'h3);
      chk("rst_feed", 32'(feed), 32'h0);
      chk("rst_rfd", 32'(rfd), 32'h0);
      chk("rst_cnt", 32'(cnt), 32'h0);
      tick_to(3);  chk("feed_n3", 32'(feed), 32'h0);
      tick_to(4);  chk("feed_n4", 32'(feed), 32'h3);
                   chk("rev_n4", 32'(rev), 32'h0);
      tick_to(5);  chk("feed_n5", 32'(feed), 32'h0);
                   chk("cnt_n5", 32'(cnt), 32'h2);
      tick_to(8);  chk("rev_n8", 32'(rev), 32'h0);
      tick_to(9);  chk("rev_n9", 32'(rev), 32'h3);

      // store runs empty, auto refill after 5 clocks
      tick_to(36); chk("feed_n36", 32'(feed), 32'h3);
                   chk("rem_n36", 32'(rem), 32'h3);
      tick_to(37); chk("rem_n37", 32'(rem), 32'h0);
                   chk("cnt_n37", 32'(cnt), 32'h6);
      tick_to(41); chk("rem_n41", 32'(rem), 32'h0);
                   chk("rfd_n41", 32'(rfd), 32'h0);
      tick_to(42); chk("rem_n42", 32'(rem), 32'h3);
                   chk("rfd_n42", 32'(rfd), 32'h3);
                   chk("m_rem_n42", 32'(rem_m), 32'h0);
                   chk("m_rfd_n42", 32'(rfd_m), 32'h0);
      refill_m = 2'b01;
      tick_to(43); refill_m = 2'b00;
                   chk("m_rem_n43", 32'(rem_m), 32'h1);
                   chk("m_rfd_n43", 32'(rfd_m), 32'h1);
                   chk("rfd_n43", 32'(rfd), 32'h0);
      tick_to(52); chk("feed_n52", 32'(feed), 32'h3);
      tick_to(53); chk("cnt_n53", 32'(cnt), 32'h8);

      // hold on the drop point: one feed, then parked at 11
      tick_to(68); chk("feed_n68", 32'(feed), 32'h3);
      x = 2'b10;
      tick_to(69); chk("feed_n69", 32'(feed), 32'h0);
                   chk("cnt_n69", 32'(cnt), 32'ha);
      tick_to(72); chk("feed_n72", 32'(feed), 32'h0);
                   chk("cnt_n72", 32'(cnt), 32'ha);
      x = 2'b11;
      tick_to(84); chk("feed_n84", 32'(feed), 32'h2);
      tick_to(87); chk("feed_n87", 32'(feed), 32'h1);
                   chk("m_feed_n87", 32'(feed_m), 32'h1);
      tick_to(88); chk("cnt_n88", 32'(cnt), 32'hc);
      tick_to(100); chk("m_rem_n100", 32'(rem_m), 32'h0);

      // empty store parked on the drop point: no feed until refilled
      tick_to(103); chk("m_feed_n103", 32'(feed_m), 32'h0);
                    chk("feed_n103", 32'(feed), 32'h1);
      x = 2'b10;
      tick_to(106); chk("m_feed_n106", 32'(feed_m), 32'h0);
      refill_m = 2'b01;
      tick_to(107); refill_m = 2'b00;
                    chk("m_rem_n107", 32'(rem_m), 32'h1);
                    chk("m_feed_n107", 32'(feed_m), 32'h1);
      tick_to(108); chk("m_feed_n108", 32'(feed_m), 32'h0);

      // counter saturation and clear, stores kept full by requests
      rst = 1'b1; x = 2'b11; refill_req = 2'b11;
      tick(1);
      rst = 1'b0; n = 0;
      chk("r2_rfd_n0", 32'(rfd), 32'h0);
      tick_to(1);   chk("r2_rfd_n1", 32'(rfd), 32'h3);
      tick_to(101); chk("cnt_n101", 32'(cnt), 32'he);
      tick_to(116); chk("feed_c116", 32'(feed), 32'h3);
                    chk("cnt_n116", 32'(cnt), 32'he);
      tick_to(117); chk("cnt_sat117", 32'(cnt), 32'hf);
      tick_to(133); chk("cnt_sat133", 32'(cnt), 32'hf);
      cnt_clr = 1'b1;
      tick_to(134); cnt_clr = 1'b0;
                    chk("cnt_clr134", 32'(cnt), 32'h0);
      tick_to(148); chk("feed_c148", 32'(feed), 32'h3);
      cnt_clr = 1'b1;
      tick_to(149); cnt_clr = 1'b0;
                    chk("cnt_clr149", 32'(cnt), 32'h0);

      // freeze on the drop point for 7 clocks
      tick_to(164); chk("feed_c164", 32'(feed), 32'h3);
      en = 1'b0; #1;
      chk("frz_feed0", 32'(feed), 32'h0);
      tick_to(170); chk("frz_feed", 32'(feed), 32'h0);
                    chk("frz_cnt", 32'(cnt), 32'h0);
                    chk("frz_rev", 32'(rev), 32'h0);
      tick_to(171); en = 1'b1; #1;
                    chk("unfrz_feed", 32'(feed), 32'h3);
      tick_to(172); chk("unfrz_cnt", 32'(cnt), 32'h2);
                    chk("unfrz_rfd", 32'(rfd), 32'h3);
                    chk("unfrz_feed1", 32'(feed), 32'h0);

      // reset mid-run
      rst = 1'b1;
      tick_to(173); rst = 1'b0;
                    chk("r3_rev", 32'(rev), 32'h3);
                    chk("r3_rem", 32'(rem), 32'h3);
                    chk("r3_feed", 32'(feed), 32'h0);
                    chk("r3_rfd", 32'(rfd), 32'h0);
                    chk("r3_cnt", 32'(cnt), 32'h0);
      tick_to(177); chk("r3_feed4", 32'(feed), 32'h3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
